pipe_hazard_ctrl: RTL

Central pipeline controller for the 5-stage IF/ID/EX/MEM/WB core. It generates per-stage stall, bubble and flush controls, and EX-stage forwarding selects. It sequences multi-cycle data-memory accesses with a timeout and drains the pipeline on a halt instruction. It fills the Controller slot in the core top and drives the pipeline-register enables and clears.

---
 rtl/pipe_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central hazard / sequencing controller for the 5-stage IF/ID/EX/MEM/WB core.
// Produces the per-stage hold (stall), clear (flush/bubble) controls and the
// EX-stage operand forwarding selects. It also sequences multi-cycle
// data-memory accesses with a timeout and drains the pipeline when a halt
// instruction is decoded.
//
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN
//   When defined, adds saturating performance counters stall_cycles,
//   flush_events and fwd_events. The default build leaves them out.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   id_rs1/id_rs2       source registers of the ID instruction
//   id_use_rs1/rs2      ID instruction actually reads rs1/rs2
//   id_halt             ID holds a halt instruction
//   ex_rs1/ex_rs2       source registers of the EX instruction
//   ex_rd, ex_is_load   destination / load flag of the EX instruction
//   mem_rd, mem_reg_write  destination / write flag of the MEM instruction
//   wb_rd, wb_reg_write    destination / write flag of the WB instruction
//   mem_branch_taken    branch in EX/MEM resolved taken
//   mem_req, mem_ready  data-memory access handshake (see below)
//   pc_stall, *_stall   hold PC / pipeline registers
//   *_flush, mem_wb_bubble  clear pipeline registers
//   fwd_a, fwd_b        EX operand select: 00 regfile, 01 MEM, 10 WB
//   halt                core halted (registered)
//   mem_err             data-memory timeout (registered, sticky)
//   dbg_state           current FSM state (RUN/DRAIN/HALTED/ERR)
//
// Memory handshake: mem_req is the request ("valid") held by the MEM stage for
// the whole access; mem_ready is the completion ("ready"). The access
// completes in the cycle where both are high. Any cycle with mem_req high and
// mem_ready low freezes the whole pipeline, and mem_req must stay high until
// the completing cycle.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int RA_W         = 5,
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_halt,
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_is_load,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic            mem_branch_taken,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_stall,
  output logic            if_id_stall,
  output logic            id_ex_stall,
  output logic            ex_mem_stall,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic            mem_wb_bubble,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            halt,
  output logic            mem_err,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_events,
  output logic [31:0]     fwd_events,
`endif
  output logic [1:0]      dbg_state
);

  // -------------------------------------------------------------------------
  // State encoding and counter widths
  // -------------------------------------------------------------------------
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic [DC_W-1:0] r_drain_cnt;
  logic            r_halt;
  logic            r_mem_err;

  // -------------------------------------------------------------------------
  // Combinational hazard detection
  // -------------------------------------------------------------------------
  logic w_active;       // RUN or DRAIN: pipeline is live
  logic w_stopped;      // HALTED or ERR: pipeline permanently frozen
  logic w_freeze;       // outstanding data-memory access
  logic w_branch;       // taken branch, effective this cycle
  logic w_load_use_raw; // raw load-use dependency ID <- EX
  logic w_load_use;     // effective load-use stall
  logic w_drain_hold;   // DRAIN keeps fetch blocked and IF/ID empty

  always_comb begin
    w_active  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    w_stopped = (r_state == ST_HALTED) || (r_state == ST_ERR);
    w_freeze  = w_active && mem_req && !mem_ready;
    w_branch  = w_active && !w_freeze && mem_branch_taken;

    w_load_use_raw = ex_is_load && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

    // Only evaluated in RUN: in DRAIN, IF/ID is being flushed every cycle,
    // so the ID slot never holds a real instruction to protect, and a stall
    // of IF/ID would fight the flush.
    w_load_use = (r_state == ST_RUN) && !w_freeze && !mem_branch_taken &&
                 w_load_use_raw;

    // A taken branch during DRAIN squashes the halt; the PC must then be
    // free to load the branch target, so the drain hold drops that cycle.
    w_drain_hold = (r_state == ST_DRAIN) && !w_freeze && !mem_branch_taken;
  end

  // -------------------------------------------------------------------------
  // Stage controls. Everything is forced low while rst is high.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst) begin
      pc_stall      = w_freeze || w_stopped || w_load_use || w_drain_hold;
      if_id_stall   = w_freeze || w_stopped || w_load_use;
      id_ex_stall   = w_freeze || w_stopped;
      ex_mem_stall  = w_freeze || w_stopped;
      mem_wb_bubble = w_freeze || w_stopped;
      if_id_flush   = w_branch || w_drain_hold;
      id_ex_flush   = w_branch || w_load_use;
      ex_mem_flush  = w_branch;
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding: the MEM-stage result is younger than WB, so it wins.
  // Register 0 is hard-wired and never forwarded.
  // -------------------------------------------------------------------------
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
        fwd_a = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
        fwd_a = FWD_WB;
      end
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
        fwd_b = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
        fwd_b = FWD_WB;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  logic [1:0]      w_state_nxt;
  logic [WC_W-1:0] w_wait_nxt;
  logic [DC_W-1:0] w_drain_nxt;
  logic            w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    // The wait counter runs only across consecutive freeze cycles.
    w_wait_nxt  = w_freeze ? (r_wait_cnt + 1'b1) : '0;
    w_timeout   = w_freeze && (r_wait_cnt == WAIT_LAST);

    case (r_state)
      ST_RUN: begin
        if (w_timeout) begin
          w_state_nxt = ST_ERR;
        end else if (id_halt && !w_freeze && !mem_branch_taken &&
                     !w_load_use_raw) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = '0;
        end
      end
      ST_DRAIN: begin
        if (w_timeout) begin
          w_state_nxt = ST_ERR;
        end else if (!w_freeze) begin
          if (mem_branch_taken) begin
            w_state_nxt = ST_RUN;
          end else if (r_drain_cnt == DRAIN_LAST) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_drain_nxt = r_drain_cnt + 1'b1;
          end
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      ST_ERR:    w_state_nxt = ST_ERR;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. halt/mem_err follow the state being entered so they
  // assert on the same edge as HALTED/ERR.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
      r_halt      <= 1'b0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_halt      <= (w_state_nxt == ST_HALTED) || (w_state_nxt == ST_ERR);
      r_mem_err   <= (w_state_nxt == ST_ERR);
    end
  end

  assign halt      = r_halt;
  assign mem_err   = r_mem_err;
  assign dbg_state = r_state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // -------------------------------------------------------------------------
  // Saturating performance counters, live only in RUN/DRAIN.
  // -------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;
  logic [31:0] r_fwd_events;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
      r_fwd_events   <= '0;
    end else if (w_active) begin
      if (pc_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (ex_mem_flush && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + 32'd1;
      end
      if (((fwd_a != FWD_RF) || (fwd_b != FWD_RF)) && (r_fwd_events != '1)) begin
        r_fwd_events <= r_fwd_events + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
  assign fwd_events   = r_fwd_events;
`endif

endmodule
